sync_filter_bank: RTL and testbench



---
 rtl/sync_filter_chan.sv | 79 +++++++
 rtl/sync_filter_bank.sv | 60 ++++++
 tb/tb_sync_filter_bank.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sync_filter_chan.sv
// One conditioned input channel: synchroniser chain, persistence filter and
// registered rise/fall pulses.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

module sync_filter_chan #(
    parameter int   STAGES = 2,
    parameter int   FILT   = 4,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d_in,
    output logic d_out,
    output logic rise,
    output logic fall,
    output logic rise_nxt,
    output logic fall_nxt
);

    localparam int              CNT_W   = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT - 1);

    logic [STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              sampled;

    assign sampled = sync_q[STAGES-1];

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
        out_d  = out_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sampled == out_q) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                out_d  = sampled;
                cnt_d  = '0;
                rise_d = sampled;
                fall_d = ~sampled;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= `BSV_ASSIGNMENT_DELAY {STAGES{INIT}};
            out_q  <= `BSV_ASSIGNMENT_DELAY INIT;
            cnt_q  <= `BSV_ASSIGNMENT_DELAY '0;
            rise_q <= `BSV_ASSIGNMENT_DELAY 1'b0;
            fall_q <= `BSV_ASSIGNMENT_DELAY 1'b0;
        end else begin
            sync_q <= `BSV_ASSIGNMENT_DELAY sync_d;
            out_q  <= `BSV_ASSIGNMENT_DELAY out_d;
            cnt_q  <= `BSV_ASSIGNMENT_DELAY cnt_d;
            rise_q <= `BSV_ASSIGNMENT_DELAY rise_d;
            fall_q <= `BSV_ASSIGNMENT_DELAY fall_d;
        end
    end

    assign d_out    = out_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign rise_nxt = rise_d;
    assign fall_nxt = fall_d;

endmodule

// File: rtl/sync_filter_bank.sv
// WIDTH independent input conditioners plus a registered CHANGED flag that
// is high whenever any channel pulses RISE or FALL.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

module sync_filter_bank #(
    parameter int               WIDTH  = 8,
    parameter int               STAGES = 2,
    parameter int               FILT   = 4,
    parameter logic [WIDTH-1:0] INIT   = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] D_IN,
    output logic [WIDTH-1:0] D_OUT,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             CHANGED
);

    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;
    logic             changed_q, changed_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_filter_chan #(
            .STAGES (STAGES),
            .FILT   (FILT),
            .INIT   (INIT[i])
        ) u_chan (
            .clk      (CLK),
            .rst      (RST),
            .en       (EN),
            .d_in     (D_IN[i]),
            .d_out    (D_OUT[i]),
            .rise     (RISE[i]),
            .fall     (FALL[i]),
            .rise_nxt (rise_nxt[i]),
            .fall_nxt (fall_nxt[i])
        );
    end

    // Built from next-state pulses so CHANGED lines up with RISE/FALL.
    always_comb begin
        changed_d = |(rise_nxt | fall_nxt);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            changed_q <= `BSV_ASSIGNMENT_DELAY 1'b0;
        end else begin
            changed_q <= `BSV_ASSIGNMENT_DELAY changed_d;
        end
    end

    assign CHANGED = changed_q;

endmodule

// File: tb/tb_sync_filter_bank.sv
// Directed checks of sync_filter_bank with default parameters (WIDTH=8,
// STAGES=2, FILT=4, INIT=0); "edge n" counts posedges after stimulus is applied.
`timescale 1ns/1ps

module tb_sync_filter_bank;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN  = 1'b0;
    logic [7:0] D_IN = 8'h00;
    logic [7:0] D_OUT, RISE, FALL;
    logic       CHANGED;

    int n_checks = 0;
    int n_errors = 0;

    sync_filter_bank dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .D_IN    (D_IN),
        .D_OUT   (D_OUT),
        .RISE    (RISE),
        .FALL    (FALL),
        .CHANGED (CHANGED)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one posedge and settle 1ns past it before sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_out,
                             input logic [7:0] e_rise, input logic [7:0] e_fall,
                             input logic e_chg);
        check({tag, ".dout"}, D_OUT, e_out);
        check({tag, ".rise"}, RISE, e_rise);
        check({tag, ".fall"}, FALL, e_fall);
        check({tag, ".chg"}, {7'd0, CHANGED}, {7'd0, e_chg});
    endtask

    task automatic do_reset(input logic [7:0] din);
        RST  = 1'b1;
        D_IN = din;
        repeat (3) step();
        RST = 1'b0;
    endtask

    initial begin
        // Reset defaults: inputs all high while reset held.
        RST  = 1'b1;
        EN   = 1'b1;
        D_IN = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            step();
            check_all("rst_hold", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        RST = 1'b0;
        step();
        check_all("rst_rel", 8'h00, 8'h00, 8'h00, 1'b0);

        // Clean rising edge on channel 0: accepted after edge 6.
        do_reset(8'h00);
        EN   = 1'b1;
        D_IN = 8'h01;
        for (int e = 1; e <= 5; e++) begin
            step();
            check_all("clean_wait", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        step();
        check_all("clean_e6", 8'h01, 8'h01, 8'h00, 1'b1);
        step();
        check_all("clean_e7", 8'h01, 8'h00, 8'h00, 1'b0);

        // Glitch on channel 1: three cycles high only reaches cnt=3, then clears.
        do_reset(8'h00);
        EN   = 1'b1;
        D_IN = 8'h02;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 3) D_IN = 8'h00;
            check_all("glitch", 8'h00, 8'h00, 8'h00, 1'b0);
        end

        // Enable gating on channel 2: EN=1 on edges 1..3, then alternates 0,1,...
        do_reset(8'h00);
        D_IN = 8'h04;
        for (int e = 1; e <= 8; e++) begin
            EN = (e < 3) ? 1'b1 : ((e - 3) % 2 == 0);
            step();
            check_all("en_wait", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        EN = 1'b1;
        step();
        check_all("en_e9", 8'h04, 8'h04, 8'h00, 1'b1);
        step();
        check_all("en_e10", 8'h04, 8'h00, 8'h00, 1'b0);

        // Reset mid-filter on channel 3: RST sampled at edge 6 (the would-be
        // accept edge) reloads the chain, so acceptance moves to edge 12.
        do_reset(8'h00);
        EN   = 1'b1;
        D_IN = 8'h08;
        for (int e = 1; e <= 11; e++) begin
            RST = (e == 6);
            step();
            check_all("midrst_wait", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        RST = 1'b0;
        step();
        check_all("midrst_e12", 8'h08, 8'h08, 8'h00, 1'b1);
        step();
        check_all("midrst_e13", 8'h08, 8'h00, 8'h00, 1'b0);

        // Simultaneous fall on channel 7 and rise on channel 0.
        do_reset(8'h00);
        EN   = 1'b1;
        D_IN = 8'h80;
        repeat (7) step();
        check_all("sim_pre", 8'h80, 8'h00, 8'h00, 1'b0);
        D_IN = 8'h01;
        for (int e = 1; e <= 5; e++) begin
            step();
            check_all("sim_wait", 8'h80, 8'h00, 8'h00, 1'b0);
        end
        step();
        check_all("sim_e6", 8'h01, 8'h01, 8'h80, 1'b1);
        step();
        check_all("sim_e7", 8'h01, 8'h00, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
